// File: rtl/mem_access_unit.sv
// Sequences one MIPS load/store into byte-wide big-endian accesses to an 8-bit RAM.
// Optional MAU_RANGE_CHECK_EN: flag any address beyond the RAM as an error instead of wrapping.
module mem_access_unit #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dout
);
    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t      state_reg;
    logic        we_reg;
    logic        sext_reg;
    logic [1:0]  size_reg;
    logic [31:0] wdata_reg;
    logic [1:0]  idx_reg;
    logic [1:0]  last_reg;
    logic [23:0] asm_reg;

    logic [1:0]  last_in;
    logic        upper_bad;
    logic        bad_req;
    logic [31:0] full_word;
    logic [31:0] load_val;

    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] k);
        pick_byte = w[{k, 3'b000} +: 8];
    endfunction

    always_comb begin
        case (size)
            2'b00:   last_in = 2'd0;
            2'b01:   last_in = 2'd1;
            default: last_in = 2'd3;
        endcase
    end

`ifdef MAU_RANGE_CHECK_EN
    assign upper_bad = |addr[31:ADDR_W];
`else
    // Upper address bits are deliberately ignored so accesses wrap into the RAM.
    assign upper_bad = (|addr[31:ADDR_W]) & 1'b0;
`endif

    assign bad_req = (size == 2'b11) ||
                     (size == 2'b01 && addr[0]) ||
                     (size == 2'b10 && addr[1:0] != 2'b00) ||
                     upper_bad;

    // The final byte arrives on mem_dout in the same cycle it is folded in.
    assign full_word = {asm_reg, mem_dout};

    always_comb begin
        case (size_reg)
            2'b00:   load_val = {{24{sext_reg & mem_dout[7]}}, mem_dout};
            2'b01:   load_val = {{16{sext_reg & full_word[15]}}, full_word[15:0]};
            default: load_val = full_word;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            we_reg    <= 1'b0;
            sext_reg  <= 1'b0;
            size_reg  <= 2'b00;
            wdata_reg <= 32'd0;
            idx_reg   <= 2'd0;
            last_reg  <= 2'd0;
            asm_reg   <= 24'd0;
            rdata     <= 32'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_en    <= 1'b0;
            mem_rw    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= 8'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (req) begin
                        we_reg    <= we;
                        sext_reg  <= sign_ext;
                        size_reg  <= size;
                        wdata_reg <= wdata;
                        last_reg  <= last_in;
                        idx_reg   <= 2'd0;
                        asm_reg   <= 24'd0;
                        busy      <= 1'b1;
                        if (bad_req) begin
                            state_reg <= DONE;
                            done      <= 1'b1;
                            err       <= 1'b1;
                        end else begin
                            state_reg <= XFER;
                            mem_en    <= 1'b1;
                            mem_rw    <= we;
                            mem_addr  <= addr[ADDR_W-1:0];
                            mem_din   <= we ? pick_byte(wdata, last_in) : 8'd0;
                        end
                    end
                end
                XFER: begin
                    asm_reg <= {asm_reg[15:0], mem_dout};
                    if (idx_reg == last_reg) begin
                        state_reg <= DONE;
                        done      <= 1'b1;
                        mem_en    <= 1'b0;
                        mem_rw    <= 1'b0;
                        mem_din   <= 8'd0;
                        if (!we_reg) begin
                            rdata <= load_val;
                        end
                    end else begin
                        idx_reg  <= idx_reg + 2'd1;
                        mem_addr <= mem_addr + 1'b1;
                        // Bytes leave MSB first: byte (N-1-idx) of the store word.
                        mem_din  <= we_reg ? pick_byte(wdata_reg, last_reg - idx_reg - 2'd1) : 8'd0;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    err       <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    err       <= 1'b0;
                    mem_en    <= 1'b0;
                    mem_rw    <= 1'b0;
                    mem_din   <= 8'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: RAM model plus a byte-array reference model of load/store semantics.
module tb_mem_access_unit;
    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

    logic          clk      = 1'b0;
    logic          reset_n  = 1'b0;
    logic          req      = 1'b0;
    logic          we       = 1'b0;
    logic [1:0]    size     = 2'b00;
    logic          sign_ext = 1'b0;
    logic [31:0]   addr     = 32'd0;
    logic [31:0]   wdata    = 32'd0;
    logic [31:0]   rdata;
    logic          busy;
    logic          done;
    logic          err;
    logic          mem_en;
    logic          mem_rw;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic [7:0]    mem_dout;

    logic [7:0]    ram     [0:DEPTH-1];
    logic [7:0]    ref_mem [0:DEPTH-1];
    logic          poke_en   = 1'b0;
    logic [AW-1:0] poke_addr = '0;
    logic [7:0]    poke_data = 8'd0;

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] exp_rdata  = 32'd0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .we(we), .size(size),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .rdata(rdata),
        .busy(busy), .done(done), .err(err), .mem_en(mem_en), .mem_rw(mem_rw),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // RAM: combinational read, synchronous write; bench-side poke port for preloading.
    assign mem_dout = ram[mem_addr];
    always @(posedge clk) begin
        if (poke_en) ram[poke_addr] <= poke_data;
        else if (mem_en && mem_rw) ram[mem_addr] <= mem_din;
    end

    function automatic int nbytes(input logic [1:0] s);
        return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit is_err(input logic [1:0] s, input logic [31:0] a);
        if (s == 2'b11) return 1'b1;
        if (s == 2'b01 && a[0]) return 1'b1;
        if (s == 2'b10 && a[1:0] != 2'b00) return 1'b1;
`ifdef MAU_RANGE_CHECK_EN
        if (a[31:AW] != '0) return 1'b1;
`endif
        return 1'b0;
    endfunction

    task automatic poke(input int a, input logic [7:0] d);
        poke_en   = 1'b1;
        poke_addr = a[AW-1:0];
        poke_data = d;
        @(posedge clk); #1;
        poke_en   = 1'b0;
        ref_mem[a % DEPTH] = d;
    endtask

    task automatic do_op(input string name, input logic w, input logic [1:0] s, input logic se,
                         input logic [31:0] a, input logic [31:0] d, input bit chain);
        int n, cnt, busy_cnt, en_cnt, exp_lat, base;
        bit e;
        logic [31:0] v;
        n       = nbytes(s);
        e       = is_err(s, a);
        exp_lat = e ? 1 : n + 1;
        base    = int'(a[AW-1:0]);
        we = w; size = s; sign_ext = se; addr = a; wdata = d;
        cnt = 0;
        while (busy && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        req = 1'b1;
        cnt = 0; busy_cnt = 0; en_cnt = 0;
        while (cnt < 30) begin
            @(posedge clk); #1;
            cnt++;
            if (busy) busy_cnt++;
            if (mem_en) en_cnt++;
            if (done) break;
        end
        compared++;
        if (done !== 1'b1) begin
            mismatched++;
            $display("FAIL %s timeout: done=%b after %0d cycles, required 1", name, done, cnt);
            req = 1'b0;
            reset_n = 1'b0; #2; reset_n = 1'b1;
            exp_rdata = 32'd0;
            return;
        end
        if (!e) begin
            if (w) begin
                for (int i = 0; i < n; i++) ref_mem[(base + i) % DEPTH] = d[8*(n-1-i) +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_mem[(base + i) % DEPTH]);
                if (se && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
                exp_rdata = v;
            end
        end
        $display("op %s we=%0d size=%0d sext=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
                 name, w, s, se, a, d, rdata, err, cnt);
        compared++;
        if (cnt != exp_lat) begin
            mismatched++;
            $display("FAIL %s latency: got %0d cycles, required %0d", name, cnt, exp_lat);
        end
        compared++;
        if (err !== e) begin
            mismatched++;
            $display("FAIL %s err: got %b, required %b", name, err, e);
        end
        compared++;
        if (rdata !== exp_rdata) begin
            mismatched++;
            $display("FAIL %s rdata: got %h, required %h", name, rdata, exp_rdata);
        end
        compared++;
        if (en_cnt != (e ? 0 : n)) begin
            mismatched++;
            $display("FAIL %s mem_en cycles: got %0d, required %0d", name, en_cnt, e ? 0 : n);
        end
        compared++;
        if (busy_cnt != cnt) begin
            mismatched++;
            $display("FAIL %s busy cycles: got %0d, required %0d", name, busy_cnt, cnt);
        end
        if (w && !e) begin
            for (int i = 0; i < n; i++) begin
                compared++;
                if (ram[(base + i) % DEPTH] !== ref_mem[(base + i) % DEPTH]) begin
                    mismatched++;
                    $display("FAIL %s ram[%0h]: got %h, required %h", name, (base + i) % DEPTH,
                             ram[(base + i) % DEPTH], ref_mem[(base + i) % DEPTH]);
                end
            end
        end
        if (!chain) begin
            req = 1'b0;
            @(posedge clk); #1;
            compared++;
            if ({busy, done, err} !== 3'b000) begin
                mismatched++;
                $display("FAIL %s idle: busy/done/err=%b, required 000", name, {busy, done, err});
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (rdata !== 32'd0) begin mismatched++; $display("FAIL reset rdata: got %h, required 0", rdata); end
        compared++;
        if (busy !== 1'b0) begin mismatched++; $display("FAIL reset busy: got %b, required 0", busy); end
        compared++;
        if (done !== 1'b0) begin mismatched++; $display("FAIL reset done: got %b, required 0", done); end
        compared++;
        if (err !== 1'b0) begin mismatched++; $display("FAIL reset err: got %b, required 0", err); end
        compared++;
        if (mem_en !== 1'b0) begin mismatched++; $display("FAIL reset mem_en: got %b, required 0", mem_en); end
        compared++;
        if (mem_rw !== 1'b0) begin mismatched++; $display("FAIL reset mem_rw: got %b, required 0", mem_rw); end
        compared++;
        if (mem_addr !== '0) begin mismatched++; $display("FAIL reset mem_addr: got %h, required 0", mem_addr); end
        compared++;
        if (mem_din !== 8'd0) begin mismatched++; $display("FAIL reset mem_din: got %h, required 0", mem_din); end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) poke(i, 8'($urandom));
    endtask

    task automatic test_word;
        do_op("word_store", 1'b1, 2'b10, 1'b0, 32'h008, 32'h1122_3344, 1'b0);
        do_op("word_load", 1'b0, 2'b10, 1'b0, 32'h008, 32'h0, 1'b0);
        compared++;
        if (rdata !== 32'h1122_3344) begin
            mismatched++;
            $display("FAIL word_roundtrip: got %h, required 11223344", rdata);
        end
    endtask

    task automatic test_byte_ext;
        poke(32'h00D, 8'h80);
        do_op("byte_load_s", 1'b0, 2'b00, 1'b1, 32'h00D, 32'h0, 1'b0);
        do_op("byte_load_u", 1'b0, 2'b00, 1'b0, 32'h00D, 32'h0, 1'b0);
    endtask

    task automatic test_half;
        do_op("half_store", 1'b1, 2'b01, 1'b0, 32'h3FE, 32'h0000_BEEF, 1'b0);
        do_op("half_load_s", 1'b0, 2'b01, 1'b1, 32'h3FE, 32'h0, 1'b0);
    endtask

    task automatic test_errors;
        do_op("half_misaligned", 1'b0, 2'b01, 1'b0, 32'h003, 32'h0, 1'b0);
        do_op("size_illegal", 1'b1, 2'b11, 1'b0, 32'h020, 32'hDEAD_BEEF, 1'b0);
        do_op("word_misaligned", 1'b1, 2'b10, 1'b0, 32'h022, 32'hCAFE_F00D, 1'b0);
    endtask

    task automatic test_upper_addr;
        poke(0, 8'h12); poke(1, 8'h34); poke(2, 8'h56); poke(3, 8'h78);
        do_op("upper_addr_load", 1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 1'b0);
    endtask

    task automatic test_back_to_back;
        do_op("b2b_store", 1'b1, 2'b10, 1'b0, 32'h100, 32'h0102_0304, 1'b1);
        do_op("b2b_load", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 1'b0);
    endtask

    task automatic test_random;
        logic [1:0] s;
        logic [31:0] a;
        int low;
        for (int k = 0; k < 40; k++) begin
            s   = 2'($urandom_range(0, 3));
            low = $urandom_range(0, DEPTH - 1);
            if ($urandom % 4 != 0) low = low & ~(nbytes(s) - 1);
            a = 32'(low);
            if ($urandom % 5 == 0) a = ($urandom & 32'hFFFF_FC00) | a;
            do_op("random", 1'($urandom), s, 1'($urandom), a, $urandom, ($urandom % 3) == 0);
        end
        do_op("random_tail", 1'b0, 2'b00, 1'b0, 32'h001, 32'h0, 1'b0);
    endtask

    task automatic test_reset_abort;
        poke(32'h012, 8'h5A);
        poke(32'h013, 8'hA5);
        we = 1'b1; size = 2'b10; sign_ext = 1'b0; addr = 32'h010; wdata = 32'hAABB_CCDD;
        req = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        req = 1'b0;
        #1;
        $display("op abort we=1 size=2 addr=00000010 wdata=aabbccdd -> reset during transfer");
        compared++;
        if ({mem_en, busy, done} !== 3'b000) begin
            mismatched++;
            $display("FAIL abort outputs: mem_en/busy/done=%b, required 000", {mem_en, busy, done});
        end
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        reset_n = 1'b1;
        ref_mem[32'h010] = 8'hAA;
        ref_mem[32'h011] = 8'hBB;
        exp_rdata = 32'd0;
        repeat (2) begin @(posedge clk); #1; end
        for (int i = 32'h010; i <= 32'h013; i++) begin
            compared++;
            if (ram[i] !== ref_mem[i]) begin
                mismatched++;
                $display("FAIL abort ram[%0h]: got %h, required %h", i, ram[i], ref_mem[i]);
            end
        end
        compared++;
        if ({rdata, done, busy} !== {exp_rdata, 2'b00}) begin
            mismatched++;
            $display("FAIL abort post-state: rdata=%h done=%b busy=%b, required 0/0/0", rdata, done, busy);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte_ext();
        test_half();
        test_errors();
        test_upper_addr();
        test_back_to_back();
        test_random();
        test_reset_abort();
        do_op("post_abort_load", 1'b0, 2'b10, 1'b0, 32'h010, 32'h0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

- Sequences one MIPS load/store from the MEM pipeline stage into byte-wide accesses to the data RAM (`memory`, 8-bit data, 10-bit address).
- Sits directly upstream of the RAM and drives its `Enable`, `ReadWrite`, `Address` and `DataIn` inputs.
- Handles byte, halfword and word sizes with big-endian byte order and load sign/zero extension.
- Stalls the pipeline until the transfer is complete.

## Interface
- `ADDR_W`, default 10: RAM address width.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset_n` in 1: asynchronous reset, active low.
- `req` in 1: access request, level. The requester holds it until `done`.
- `we` in 1: 1 = store, 0 = load.
- `size` in 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `sign_ext` in 1: 1 = loads sign-extend, 0 = loads zero-extend.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-aligned.
- `rdata` out 32: load result, right-aligned and extended.
- `busy` out 1: stall to the pipeline.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle error pulse, coincident with `done`.
- `mem_en` out 1: RAM `Enable`.
- `mem_rw` out 1: RAM `ReadWrite`; 1 = write, 0 = read.
- `mem_addr` out ADDR_W: RAM `Address`.
- `mem_din` out 8: RAM `DataIn`.
- `mem_dout` in 8: RAM `DataOut`. The RAM read is combinational, so this is valid in the same cycle as `mem_addr`.

## Operation
- FSM states: IDLE, XFER, DONE.
- IDLE
  - `req` is sampled only in IDLE.
  - On `req`=1, capture `we`, `size`, `sign_ext`, `addr` and `wdata`.
  - Byte count N = 1/2/4 for byte/half/word.
  - Index register `idx` = 0.
- Error detection happens at acceptance. The request is an error if:
  - `size`=11, or
  - a halfword has `addr[0]`≠0, or
  - a word has `addr[1:0]`≠0.
- On error: go straight to DONE with `err`=1; the RAM is never enabled.
- On a legal request: go to XFER.
- XFER, each cycle
  - `mem_en`=1, `mem_rw`=`we`, `mem_addr` = `addr[ADDR_W-1:0]` + `idx`.
  - Address arithmetic is modulo 2^ADDR_W.
  - Store: `mem_din` = byte (N-1-`idx`) of `wdata`, so the MSB byte goes to the lowest address.
  - Load: `mem_dout` is shifted into an assembly register each cycle, MSB first.
  - `idx` increments; after `idx`=N-1, go to DONE.
- DONE (exactly one cycle)
  - `done`=1.
  - On a load, `rdata` is updated: byte/half extended per `sign_ext`; a word is passed unchanged.
  - On a store or an error, `rdata` is unchanged.
  - Next state is IDLE.
- Requester rule: drop `req` in the cycle `done` is seen. If `req` is still high in IDLE, it is taken as a new request.
- `busy` = (state ≠ IDLE), registered.
- Outside XFER: `mem_en`=0, `mem_rw`=0, `mem_din`=0, `mem_addr` holds its last value.

## Timing
- Reset values: `rdata`=0, `busy`=0, `done`=0, `err`=0, `mem_en`=0, `mem_rw`=0, `mem_addr`=0, `mem_din`=0; state = IDLE.
- Latency, legal request: acceptance edge → N XFER cycles → DONE. `done` is high N+1 cycles after the accepting edge. Word = 5 cycles, half = 3, byte = 2.
- Latency, error: `done`/`err` are high 1 cycle after acceptance.
- `busy` rises on the accepting edge and falls on the edge that leaves DONE.
- Reset mid-XFER: `mem_en` drops immediately (asynchronously) and the state returns to IDLE.
  - Bytes already written stay written; the remaining bytes are never written.
  - No `done` is produced for the aborted request.

## Configuration
- Macro: `MAU_RANGE_CHECK_EN`.
- Defined: any nonzero `addr[31:ADDR_W]` is an error (`err` pulse, no RAM access).
- Undefined: the upper address bits are ignored, so the access wraps into the RAM.

## Test plan
- Word store 0x11223344 at 0x008, then word load at 0x008 -> RAM[8..11] = 11,22,33,44; `rdata`=0x11223344; `done` 5 cycles after each accept; `busy` high 5 cycles.
- Preload RAM[0x00D]=0x80; byte load with `sign_ext`=1 -> `rdata`=0xFFFFFF80; with `sign_ext`=0 -> 0x00000080.
- Half store 0xBEEF at 0x3FE, then half load signed -> RAM[0x3FE]=0xBE, RAM[0x3FF]=0xEF; `rdata`=0xFFFFBEEF.
- Half load at 0x003, and separately `size`=11 -> `err` and `done` pulse 1 cycle after accept; `mem_en` never asserted; `rdata` unchanged.
- Word store 0xAABBCCDD at 0x010 with `reset_n` low after the 2nd XFER cycle -> RAM[0x10]=AA, RAM[0x11]=BB, RAM[0x12..0x13] unchanged; `mem_en`, `busy` and `done` = 0 immediately.
- Word load at 0x00000400:
  - with `MAU_RANGE_CHECK_EN` -> `err`=1 and no access;
  - without it -> reads RAM[0x000..0x003].
